// File: rtl/sssp_edge_pkg.sv
// rtl/sssp_edge_pkg.sv - shared types and constants for the SSSP edge reader
package sssp_edge_pkg;

    localparam int EDGE_CL_BITS = 512;
    localparam int CL_ADDR_W    = 42;
    localparam int EDGE_MDATA_W = 16;

    typedef logic [EDGE_CL_BITS-1:0] t_edge_line;
    typedef logic [EDGE_MDATA_W-1:0] t_edge_tag;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } t_edge_rd_state;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/sssp_edge_buf.sv
// rtl/sssp_edge_buf.sv - synchronous first-word-fall-through FIFO for read responses
module sssp_edge_buf
    import sssp_edge_pkg::*;
#(
    parameter int WIDTH = EDGE_CL_BITS + EDGE_MDATA_W,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_wr, do_rd;

    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign count = count_q;
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/sssp_edge_reader.sv
// rtl/sssp_edge_reader.sv - streams edge cache lines from host memory via CCI-P c0 reads
// Optional stall counters: SSSP_EDGE_RD_PERF_EN
module sssp_edge_reader
    import sssp_edge_pkg::*;
#(
    parameter int BUF_DEPTH       = 64,
    parameter int MAX_OUTSTANDING = 32,
    parameter int MDATA_W         = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [CL_ADDR_W-1:0]  edge_addr,
    input  logic [31:0]           edge_ncl,
    output logic                  busy,
    output logic                  done,
    input  logic                  c0_tx_alm_full,
    output logic                  rd_req_valid,
    output logic [CL_ADDR_W-1:0]  rd_req_addr,
    output logic [MDATA_W-1:0]    rd_req_mdata,
    input  logic                  rd_rsp_valid,
    input  logic [MDATA_W-1:0]    rd_rsp_mdata,
    input  t_edge_line            rd_rsp_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output t_edge_line            out_data,
    output logic [MDATA_W-1:0]    out_idx
`ifdef SSSP_EDGE_RD_PERF_EN
    ,
    output logic [31:0]           perf_almfull_stall,
    output logic [31:0]           perf_credit_stall,
    output logic [31:0]           perf_out_stall
`endif
);

    localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam int BUF_W = EDGE_CL_BITS + MDATA_W;

    t_edge_rd_state          state_q, state_d;
    logic [CL_ADDR_W-1:0]    base_q, base_d;
    logic [31:0]             ncl_q, ncl_d;
    logic [31:0]             req_cnt_q, req_cnt_d;
    logic [31:0]             out_cnt_q, out_cnt_d;
    logic [OUT_W-1:0]        outst_q, outst_d;
    logic                    rd_req_valid_q, rd_req_valid_d;
    logic [CL_ADDR_W-1:0]    rd_req_addr_q, rd_req_addr_d;
    logic [MDATA_W-1:0]      rd_req_mdata_q, rd_req_mdata_d;

    logic                    req_pending, credit_ok, issue, push, pop;
    logic [31:0]             reserved;
    logic [BUF_W-1:0]        buf_rd_data;
    logic [$clog2(BUF_DEPTH):0] buf_count;
    logic                    buf_empty, buf_full;

    // Lines in flight plus lines buffered are reserved, so every response has a slot.
    assign reserved    = 32'(outst_q) + 32'(buf_count);
    assign req_pending = (state_q == RUN) && (req_cnt_q < ncl_q);
    assign credit_ok   = (32'(outst_q) < 32'(MAX_OUTSTANDING)) && (reserved < 32'(BUF_DEPTH));
    assign issue       = req_pending && !c0_tx_alm_full && credit_ok;
    assign push        = (state_q == RUN) && rd_rsp_valid;
    assign pop         = !buf_empty && out_ready;

    always_comb begin
        state_d        = state_q;
        base_d         = base_q;
        ncl_d          = ncl_q;
        req_cnt_d      = req_cnt_q;
        out_cnt_d      = out_cnt_q;
        outst_d        = outst_q;
        rd_req_valid_d = 1'b0;
        rd_req_addr_d  = rd_req_addr_q;
        rd_req_mdata_d = rd_req_mdata_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d    = edge_addr;
                    ncl_d     = edge_ncl;
                    req_cnt_d = '0;
                    out_cnt_d = '0;
                    outst_d   = '0;
                    state_d   = (edge_ncl == 32'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (issue) begin
                    rd_req_valid_d = 1'b1;
                    rd_req_addr_d  = base_q + {{(CL_ADDR_W-32){1'b0}}, req_cnt_q};
                    rd_req_mdata_d = req_cnt_q[MDATA_W-1:0];
                    req_cnt_d      = req_cnt_q + 32'd1;
                end
                if (issue && !push) begin
                    outst_d = outst_q + 1'b1;
                end else if (!issue && push && (outst_q != '0)) begin
                    outst_d = outst_q - 1'b1;
                end
                if (pop) out_cnt_d = out_cnt_q + 32'd1;
                if (out_cnt_q == ncl_q) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            base_q         <= '0;
            ncl_q          <= '0;
            req_cnt_q      <= '0;
            out_cnt_q      <= '0;
            outst_q        <= '0;
            rd_req_valid_q <= 1'b0;
            rd_req_addr_q  <= '0;
            rd_req_mdata_q <= '0;
        end else begin
            state_q        <= state_d;
            base_q         <= base_d;
            ncl_q          <= ncl_d;
            req_cnt_q      <= req_cnt_d;
            out_cnt_q      <= out_cnt_d;
            outst_q        <= outst_d;
            rd_req_valid_q <= rd_req_valid_d;
            rd_req_addr_q  <= rd_req_addr_d;
            rd_req_mdata_q <= rd_req_mdata_d;
        end
    end

    sssp_edge_buf #(
        .WIDTH (BUF_W),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push),
        .wr_data ({rd_rsp_data, rd_rsp_mdata}),
        .rd_en   (pop),
        .rd_data (buf_rd_data),
        .count   (buf_count),
        .empty   (buf_empty),
        .full    (buf_full)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && buf_full));

    assign busy         = (state_q == RUN);
    assign done         = (state_q == DONE);
    assign rd_req_valid = rd_req_valid_q;
    assign rd_req_addr  = rd_req_addr_q;
    assign rd_req_mdata = rd_req_mdata_q;
    assign out_valid    = !buf_empty;
    assign out_data     = buf_rd_data[BUF_W-1:MDATA_W];
    assign out_idx      = buf_rd_data[MDATA_W-1:0];

`ifdef SSSP_EDGE_RD_PERF_EN
    logic [31:0] perf_almfull_q, perf_almfull_d;
    logic [31:0] perf_credit_q, perf_credit_d;
    logic [31:0] perf_out_q, perf_out_d;
    logic        perf_clr;

    assign perf_clr = (state_q == IDLE) && start;

    always_comb begin
        perf_almfull_d = perf_almfull_q;
        perf_credit_d  = perf_credit_q;
        perf_out_d     = perf_out_q;
        if (perf_clr) begin
            perf_almfull_d = '0;
            perf_credit_d  = '0;
            perf_out_d     = '0;
        end else begin
            if (req_pending && c0_tx_alm_full)
                perf_almfull_d = sat_inc32(perf_almfull_q);
            if (req_pending && !c0_tx_alm_full && !credit_ok)
                perf_credit_d = sat_inc32(perf_credit_q);
            if (out_valid && !out_ready)
                perf_out_d = sat_inc32(perf_out_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_almfull_q <= '0;
            perf_credit_q  <= '0;
            perf_out_q     <= '0;
        end else begin
            perf_almfull_q <= perf_almfull_d;
            perf_credit_q  <= perf_credit_d;
            perf_out_q     <= perf_out_d;
        end
    end

    assign perf_almfull_stall = perf_almfull_q;
    assign perf_credit_stall  = perf_credit_q;
    assign perf_out_stall     = perf_out_q;
`endif

endmodule

// File: tb/tb_sssp_edge_reader.sv
// tb/tb_sssp_edge_reader.sv - scoreboard bench for sssp_edge_reader
module tb_sssp_edge_reader;

    localparam int MW = 16;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, start, busy, done, c0_tx_alm_full;
    logic [41:0]  edge_addr, rd_req_addr;
    logic [31:0]  edge_ncl;
    logic         rd_req_valid, rd_rsp_valid, out_valid, out_ready;
    logic [MW-1:0] rd_req_mdata, rd_rsp_mdata, out_idx;
    logic [511:0] rd_rsp_data, out_data;
`ifdef SSSP_EDGE_RD_PERF_EN
    logic [31:0]  perf_almfull_stall, perf_credit_stall, perf_out_stall;
`endif

    sssp_edge_reader #(.BUF_DEPTH(64), .MAX_OUTSTANDING(32), .MDATA_W(MW)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .edge_addr      (edge_addr),
        .edge_ncl       (edge_ncl),
        .busy           (busy),
        .done           (done),
        .c0_tx_alm_full (c0_tx_alm_full),
        .rd_req_valid   (rd_req_valid),
        .rd_req_addr    (rd_req_addr),
        .rd_req_mdata   (rd_req_mdata),
        .rd_rsp_valid   (rd_rsp_valid),
        .rd_rsp_mdata   (rd_rsp_mdata),
        .rd_rsp_data    (rd_rsp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_idx        (out_idx)
`ifdef SSSP_EDGE_RD_PERF_EN
        ,
        .perf_almfull_stall (perf_almfull_stall),
        .perf_credit_stall  (perf_credit_stall),
        .perf_out_stall     (perf_out_stall)
`endif
    );

    typedef struct { int due; logic [MW-1:0] idx; } pend_t;
    typedef struct { logic [MW-1:0] idx; logic [511:0] data; } exp_t;

    pend_t         pend_q[$];
    exp_t          exp_q[$];
    logic [MW-1:0] idx_log[$];

    int   n_checks = 0, n_fail = 0, cyc = 0, lat = 3;
    int   req_seen = 0, beats = 0, done_seen = 0, busy_seen = 0, ov_seen = 0;
    bit   auto_rsp = 1'b1, expect_accept = 1'b1;
    bit   prev_busy = 1'b0, done_prev_busy = 1'b0, done_with_busy = 1'b0;
    logic [41:0] exp_base = '0;

    function automatic logic [511:0] line_of(input logic [41:0] base, input logic [MW-1:0] idx);
        logic [41:0] a;
        a = base + 42'(idx);
        return {16{a[15:0] ^ 16'h5a3c, idx}};
    endfunction

    // Monitor and memory model, evaluated just after the falling edge.
    always @(negedge clk) begin
        #1;
        cyc++;
        if (rd_req_valid) begin
            n_checks++;
            if (rd_req_addr !== exp_base + 42'(req_seen)) begin
                n_fail++;
                $display("FAIL req_addr: got %0h expected %0h", rd_req_addr, exp_base + 42'(req_seen));
            end
            n_checks++;
            if (rd_req_mdata !== req_seen[MW-1:0]) begin
                n_fail++;
                $display("FAIL req_mdata: got %0h expected %0h", rd_req_mdata, req_seen[MW-1:0]);
            end
            if (auto_rsp) pend_q.push_back('{due: cyc + lat, idx: rd_req_mdata});
            req_seen++;
        end
        if (done) begin
            done_seen++;
            done_prev_busy = prev_busy;
            if (busy) done_with_busy = 1'b1;
        end
        prev_busy = busy;
        if (busy) busy_seen++;
        if (out_valid) ov_seen++;
        if (out_valid && out_ready) begin
            exp_t e;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_empty: got beat idx %0h expected none", out_idx);
            end else begin
                e = exp_q.pop_front();
                if (out_idx !== e.idx || out_data !== e.data) begin
                    n_fail++;
                    $display("FAIL sb_beat: got idx %0h data[31:0] %0h expected idx %0h data[31:0] %0h",
                             out_idx, out_data[31:0], e.idx, e.data[31:0]);
                end
            end
            idx_log.push_back(out_idx);
            beats++;
        end
        if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            pend_t p;
            p = pend_q.pop_front();
            rd_rsp_valid = 1'b1;
            rd_rsp_mdata = p.idx;
            rd_rsp_data  = line_of(exp_base, p.idx);
            if (expect_accept) exp_q.push_back('{idx: p.idx, data: line_of(exp_base, p.idx)});
        end else begin
            rd_rsp_valid = 1'b0;
        end
    end

    task automatic reset_dut();
        @(negedge clk);
        reset = 1'b1; start = 1'b0; c0_tx_alm_full = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        pend_q.delete(); exp_q.delete(); idx_log.delete();
        req_seen = 0; beats = 0; done_seen = 0; busy_seen = 0; ov_seen = 0;
        auto_rsp = 1'b1; expect_accept = 1'b1; lat = 3;
        done_prev_busy = 1'b0; done_with_busy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic do_start(input logic [41:0] addr, input logic [31:0] ncl, input bit track);
        @(posedge clk); #1;
        if (track) exp_base = addr;
        @(negedge clk);
        start = 1'b1; edge_addr = addr; edge_ncl = ncl;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (done_seen == 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        n_checks++;
        if (done_seen == 0) begin
            n_fail++;
            $display("FAIL %s_timeout: got no done in %0d cycles expected done", name, budget);
        end
    endtask

    task automatic wait_reqs(input int target, input int budget, input string name);
        int n = 0;
        while (req_seen < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        n_checks++;
        if (req_seen < target) begin
            n_fail++;
            $display("FAIL %s_req_timeout: got %0d requests expected %0d", name, req_seen, target);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        check_int("rst_busy", int'(busy), 0);
        check_int("rst_done", int'(done), 0);
        check_int("rst_rd_req_valid", int'(rd_req_valid), 0);
        check_int("rst_out_valid", int'(out_valid), 0);
    endtask

    task automatic test_basic();
        reset_dut();
        do_start(42'h1000, 32'd8, 1'b1);
        wait_done(300, "basic");
        repeat (5) @(posedge clk);
        check_int("basic_reqs", req_seen, 8);
        check_int("basic_beats", beats, 8);
        check_int("basic_done_pulses", done_seen, 1);
        check_int("basic_busy_with_done", int'(done_with_busy), 0);
        check_int("basic_busy_before_done", int'(done_prev_busy), 1);
        check_int("basic_sb_left", exp_q.size(), 0);
    endtask

    task automatic test_reorder();
        int ord[4] = '{2, 0, 3, 1};
        reset_dut();
        auto_rsp = 1'b0;
        do_start(42'h2000, 32'd4, 1'b1);
        wait_reqs(4, 50, "reorder");
        @(posedge clk); #1;
        foreach (ord[i]) pend_q.push_back('{due: 0, idx: MW'(ord[i])});
        wait_done(100, "reorder");
        check_int("reorder_beats", beats, 4);
        for (int i = 0; i < 4; i++) begin
            if (i < idx_log.size()) check_int($sformatf("reorder_idx%0d", i), int'(idx_log[i]), ord[i]);
        end
    endtask

    task automatic test_backpressure();
        reset_dut();
        @(negedge clk);
        out_ready = 1'b0;
        do_start(42'h3000, 32'd100, 1'b1);
        repeat (300) @(posedge clk);
        check_int("bp_reqs_capped", req_seen, 64);
        repeat (30) @(posedge clk);
        check_int("bp_reqs_hold", req_seen, 64);
        check_int("bp_no_beats", beats, 0);
        @(negedge clk);
        out_ready = 1'b1;
        wait_done(2000, "bp");
        repeat (3) @(posedge clk);
        check_int("bp_reqs_total", req_seen, 100);
        check_int("bp_beats_total", beats, 100);
        check_int("bp_sb_left", exp_q.size(), 0);
    endtask

    task automatic test_almfull();
        int bad = 0;
        reset_dut();
        do_start(42'h4000, 32'd60, 1'b1);
        wait_reqs(10, 100, "almfull");
        @(negedge clk);
        c0_tx_alm_full = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rd_req_valid) bad++;
        end
        c0_tx_alm_full = 1'b0;
        check_int("almfull_req_during_stall", bad, 0);
        wait_done(1000, "almfull");
        repeat (3) @(posedge clk);
        check_int("almfull_reqs_total", req_seen, 60);
        check_int("almfull_beats_total", beats, 60);
    endtask

    task automatic test_zero();
        reset_dut();
        do_start(42'h6000, 32'd0, 1'b1);
        wait_done(5, "zero");
        repeat (4) @(posedge clk);
        check_int("zero_done_pulses", done_seen, 1);
        check_int("zero_reqs", req_seen, 0);
        check_int("zero_busy_cycles", busy_seen, 0);
    endtask

    task automatic test_start_busy();
        reset_dut();
        do_start(42'h5000, 32'd6, 1'b1);
        check_int("sb_busy_after_start", int'(busy), 1);
        do_start(42'h9000, 32'd50, 1'b0);
        wait_done(300, "start_busy");
        repeat (10) @(posedge clk);
        check_int("sb_reqs", req_seen, 6);
        check_int("sb_beats", beats, 6);
        check_int("sb_done_pulses", done_seen, 1);
    endtask

    task automatic test_reset_mid();
        reset_dut();
        lat = 25;
        expect_accept = 1'b0;
        do_start(42'h7000, 32'd40, 1'b1);
        wait_reqs(5, 50, "rst_mid");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_int("rst_mid_rd_req_valid", int'(rd_req_valid), 0);
        check_int("rst_mid_busy", int'(busy), 0);
        check_int("rst_mid_out_valid", int'(out_valid), 0);
        @(posedge clk); #1;
        ov_seen = 0;
        done_seen = 0;
        repeat (40) @(posedge clk);
        check_int("rst_mid_late_out_valid", ov_seen, 0);
        check_int("rst_mid_done", done_seen, 0);
    endtask

`ifdef SSSP_EDGE_RD_PERF_EN
    task automatic test_perf();
        int n = 0;
        reset_dut();
        @(negedge clk);
        out_ready = 1'b0;
        do_start(42'h8000, 32'd4, 1'b1);
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 50);
        check_int("perf_data_buffered", int'(out_valid), 1);
        repeat (20) @(negedge clk);
        check_int("perf_out_stall", int'(perf_out_stall), 20);
        check_int("perf_almfull_stall", int'(perf_almfull_stall), 0);
        out_ready = 1'b1;
        wait_done(200, "perf");
        check_int("perf_beats", beats, 4);
    endtask
`endif

    initial begin
        reset = 1'b1; start = 1'b0; edge_addr = '0; edge_ncl = '0;
        c0_tx_alm_full = 1'b0; out_ready = 1'b1;
        rd_rsp_valid = 1'b0; rd_rsp_mdata = '0; rd_rsp_data = '0;
        test_reset();
        test_basic();
        test_reorder();
        test_backpressure();
        test_almfull();
        test_zero();
        test_start_busy();
        test_reset_mid();
`ifdef SSSP_EDGE_RD_PERF_EN
        test_perf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sssp_edge_reader.md
Name: sssp_edge_reader

Overview:
Streams the edge array from host memory into the SSSP edge-processing pipeline. On a start pulse it issues CCI-P c0 read requests for edge_ncl consecutive cache lines starting at edge_addr. It buffers the read responses, which may return out of order, in an internal FIFO and presents them downstream as a valid/ready line stream tagged with the line index. It sits between the CSR/main FSM, which provides the addresses and the start pulse, and the edge scatter logic.

Parameters:
BUF_DEPTH, 64, response buffer depth in lines; power of 2, at least 4.
MAX_OUTSTANDING, 32, cap on in-flight read requests; must not exceed BUF_DEPTH.
MDATA_W, 16, width of the c0 mdata tag.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; samples edge_addr and edge_ncl
edge_addr  in  42  cache-line base address of the edge array
edge_ncl  in  32  number of cache lines to read
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse when the last line leaves the stream
c0_tx_alm_full  in  1  CCI-P c0TxAlmFull
rd_req_valid  out  1  c0 read request valid
rd_req_addr  out  42  request cache-line address
rd_req_mdata  out  MDATA_W  request tag = line index[MDATA_W-1:0]
rd_rsp_valid  in  1  c0 rspValid with resp_type = read
rd_rsp_mdata  in  MDATA_W  returned tag
rd_rsp_data  in  512  returned line
out_valid  out  1  stream valid
out_ready  in  1  downstream ready
out_data  out  512  edge line
out_idx  out  MDATA_W  line index of out_data

Behaviour:
- Reset: busy, done, rd_req_valid and out_valid are 0; all counters and the FIFO are cleared; state is IDLE. A reset mid-operation aborts the run. Responses that arrive later while IDLE are dropped.
- FSM states:
  - IDLE: on start, latch edge_addr and edge_ncl, zero req_cnt, out_cnt and outstanding, go to RUN. If edge_ncl == 0, go to DONE instead.
  - RUN: issue requests and drain responses. Go to DONE when out_cnt == ncl.
  - DONE: pulse done for one cycle, return to IDLE.
  - start is ignored outside IDLE.
- Issue condition (evaluated each RUN cycle), all of the following:
  - req_cnt < ncl
  - !c0_tx_alm_full
  - outstanding < MAX_OUTSTANDING
  - outstanding + fifo_count < BUF_DEPTH
- Issue output: rd_req_valid is registered, high the cycle after the condition holds. rd_req_addr = base + req_cnt, 42-bit wrap. req_cnt increments and outstanding increments. At most one request per cycle.
- Response handling: each rd_rsp_valid in RUN writes {data, mdata} into the FIFO and decrements outstanding. The reservation rule guarantees no overflow. A response arriving with a full FIFO is a design error: assertion, data dropped.
- Simultaneous issue and response in one cycle: outstanding is unchanged.
- Stream: out_valid = FIFO not empty (first-word-fall-through). A transfer occurs when out_valid && out_ready, which pops the FIFO and increments out_cnt. out_data and out_idx hold stable while out_valid && !out_ready.
- Ordering: out_idx order follows response arrival, not address order. Downstream must not assume address order.
- busy = (state == RUN).
- Counter widths: req_cnt, out_cnt, ncl are 32 bits. outstanding is clog2(MAX_OUTSTANDING)+1 bits.

Optional Feature:
SSSP_EDGE_RD_PERF_EN
- Defined: adds three 32-bit saturating counters, exposed on output ports perf_almfull_stall, perf_credit_stall and perf_out_stall:
  - cycles in RUN with a request pending but blocked by c0_tx_alm_full
  - cycles blocked by outstanding or buffer limits
  - cycles with out_valid && !out_ready
  - All three clear on reset and on accepted start.
- Undefined: the ports and counters are absent; no other behavioural difference.

Decomposition:
- Package sssp_edge_pkg:
  - t_edge_line (512-bit)
  - t_edge_tag (MDATA_W)
  - t_edge_rd_state enum {IDLE, RUN, DONE}
  - EDGE_CL_BITS = 512
  - CL_ADDR_W = 42
- One sub-module, sssp_edge_buf: synchronous first-word-fall-through FIFO.
  - Width 512 + MDATA_W, depth BUF_DEPTH.
  - Outputs count, empty and full.
  - Same clk/reset convention.

Test Plan:
- Basic run: start with addr 0x1000, ncl 8, out_ready = 1, responses in order with 3-cycle latency -> 8 requests at addresses 0x1000..0x1007 with mdata 0..7; 8 stream beats; done pulses once; busy drops the same cycle done rises.
- Reordering: ncl 4, responses return mdata 2,0,3,1 -> out_idx sequence is 2,0,3,1 with matching data; done after the 4th beat.
- Backpressure: ncl 100, out_ready = 0, BUF_DEPTH 64 -> exactly 64 requests issued, then rd_req_valid stays 0. Release out_ready -> remaining 36 issue; total 100 beats, no drop.
- AlmFull: assert c0_tx_alm_full for 10 cycles mid-run -> no rd_req_valid from the cycle after assertion until the cycle after deassertion; the final count is still correct.
- Corner cases:
  - ncl 0 -> done pulses 2 cycles after start with no requests issued.
  - start while busy -> ignored.
  - reset during RUN with 5 requests outstanding -> outputs 0 next cycle; later responses produce no out_valid.
- Perf, with SSSP_EDGE_RD_PERF_EN defined: hold out_ready low for 20 cycles with data buffered -> perf_out_stall == 20.
